// File: rtl/mips_core_pkg.sv
// Shared core definitions for the thread-switch logic.
//   ADDR_WIDTH         core-wide PC width
//   tid_t              thread identifier (two hardware threads)
//   thread_sw_state_t  state of the thread-switch initiator FSM
//   THREAD*_RESET_PC   resume PCs each thread starts from after reset
package mips_core_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef logic tid_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        REQ      = 2'd2,
        ALL_DONE = 2'd3
    } thread_sw_state_t;

    localparam logic [ADDR_WIDTH-1:0] THREAD0_RESET_PC = '0;
    localparam logic [ADDR_WIDTH-1:0] THREAD1_RESET_PC = {1'b1, {(ADDR_WIDTH-1){1'b0}}};

endpackage

// File: rtl/thread_switch_initiator_resume_pc_file.sv
// resume_pc_file: one resume PC per thread.
//   clk, rst  core clock, synchronous active-high reset (restores RESET_PC0/1)
//   we        write enable
//   waddr     thread whose PC is written
//   wdata     PC to store
//   raddr     thread whose PC is read (combinational read)
//   rdata     stored PC of raddr
module resume_pc_file
    import mips_core_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC0 = THREAD0_RESET_PC,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC1 = THREAD1_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  tid_t                  waddr,
    input  logic [ADDR_WIDTH-1:0] wdata,
    input  tid_t                  raddr,
    output logic [ADDR_WIDTH-1:0] rdata
);

    logic [ADDR_WIDTH-1:0] pc_q [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q[0] <= RESET_PC0;
            pc_q[1] <= RESET_PC1;
        end else if (we) begin
            pc_q[waddr] <= wdata;
        end
    end

    assign rdata = pc_q[raddr];

endmodule

// File: rtl/thread_switch_initiator.sv
// thread_switch_initiator: initiator side of the thread-switch protocol.
// Watches the MEM stage for switching load misses and halts, saves the
// resume PC, flushes and drains the pipeline, then requests a switch to the
// other thread from the thread controller.
//   clk, rst                  core clock, synchronous active-high reset
//   mem_valid/mem_pc          MEM-stage instruction valid and its PC
//   mem_load_miss/mem_halt    MEM-stage load miss / thread-ending instruction
//   miss_resp_valid/_tid      refill completed for the given thread
//   switch_req/switch_ack     switch handshake to the thread controller
//   switch_tid/switch_pc      target thread and its resume PC
//   cur_tid                   currently running thread
//   flush                     one-cycle pipeline flush
//   fetch_stall               hold fetch
//   thread_done/all_done      per-thread and global completion
//   dbg_state                 FSM state
//
// Handshake: switch_req is a valid, switch_ack a ready. The switch transfers
// on the cycle both are high. While switch_req is high, switch_tid and
// switch_pc do not change; an ack while switch_req is low has no effect.
module thread_switch_initiator
    import mips_core_pkg::*;
#(
    parameter int DRAIN_CYCLES   = 3,
    parameter int MIN_RUN_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic [ADDR_WIDTH-1:0] mem_pc,
    input  logic                  mem_load_miss,
    input  logic                  mem_halt,
    input  logic                  miss_resp_valid,
    input  tid_t                  miss_resp_tid,
    input  logic                  switch_ack,
    output logic                  switch_req,
    output tid_t                  switch_tid,
    output logic [ADDR_WIDTH-1:0] switch_pc,
    output tid_t                  cur_tid,
    output logic                  flush,
    output logic                  fetch_stall,
    output logic [1:0]            thread_done,
    output logic                  all_done,
    output thread_sw_state_t      dbg_state
);

    localparam int RUN_W   = (MIN_RUN_CYCLES > 0) ? $clog2(MIN_RUN_CYCLES + 1) : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    thread_sw_state_t   state_q, state_d;
    tid_t               cur_q;
    logic [RUN_W-1:0]   run_cnt_q;
    logic [DRAIN_W-1:0] drain_cnt_q;
    logic [1:0]         blocked_q, blocked_d;
    logic [1:0]         done_q;

    tid_t other;
    logic is_halt, is_miss, run_ready;
    logic pc_we, set_blocked, set_done, load_drain, do_switch;

    assign other     = ~cur_q;
    // Halt wins over a load miss on the same instruction.
    assign is_halt   = mem_valid & mem_halt;
    assign is_miss   = mem_valid & mem_load_miss & ~mem_halt;
    assign run_ready = (run_cnt_q == RUN_W'(MIN_RUN_CYCLES));

    always_comb begin
        state_d     = state_q;
        flush       = 1'b0;
        fetch_stall = 1'b0;
        switch_req  = 1'b0;
        all_done    = 1'b0;
        pc_we       = 1'b0;
        set_blocked = 1'b0;
        set_done    = 1'b0;
        load_drain  = 1'b0;
        do_switch   = 1'b0;
        case (state_q)
            RUN: begin
                if (is_halt) begin
                    set_done = 1'b1;
                    if (done_q[other]) begin
                        state_d = ALL_DONE;
                    end else begin
                        flush      = 1'b1;
                        load_drain = 1'b1;
                        state_d    = DRAIN;
                    end
                end else if (is_miss && !done_q[other] && !blocked_q[other] && run_ready) begin
                    // The missing load re-executes when this thread resumes.
                    pc_we       = 1'b1;
                    set_blocked = 1'b1;
                    flush       = 1'b1;
                    load_drain  = 1'b1;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                fetch_stall = 1'b1;
                // Leave as the counter reaches zero so fetch is held for
                // exactly DRAIN_CYCLES cycles after the flush.
                if (drain_cnt_q == '0 || drain_cnt_q == DRAIN_W'(1)) state_d = REQ;
            end
            REQ: begin
                fetch_stall = 1'b1;
                // Wait for the refill if the target thread is still blocked.
                switch_req  = ~blocked_q[other];
                if (switch_req && switch_ack) begin
                    do_switch = 1'b1;
                    state_d   = RUN;
                end
            end
            ALL_DONE: begin
                fetch_stall = 1'b1;
                all_done    = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    // A miss that blocks a thread in the same cycle as a refill for it is
    // younger than the refill, so the set takes priority.
    always_comb begin
        blocked_d = blocked_q;
        if (miss_resp_valid) blocked_d[miss_resp_tid] = 1'b0;
        if (set_blocked) blocked_d[cur_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            cur_q       <= 1'b0;
            run_cnt_q   <= '0;
            drain_cnt_q <= '0;
            blocked_q   <= '0;
            done_q      <= '0;
        end else begin
            state_q   <= state_d;
            blocked_q <= blocked_d;
            if (do_switch) begin
                cur_q     <= other;
                run_cnt_q <= '0;
            end else if (state_q == RUN && !run_ready) begin
                run_cnt_q <= run_cnt_q + RUN_W'(1);
            end
            if (load_drain) begin
                drain_cnt_q <= DRAIN_W'(DRAIN_CYCLES);
            end else if (state_q == DRAIN && drain_cnt_q != '0) begin
                drain_cnt_q <= drain_cnt_q - DRAIN_W'(1);
            end
            if (set_done) done_q[cur_q] <= 1'b1;
        end
    end

    resume_pc_file u_resume_pc_file (
        .clk   (clk),
        .rst   (rst),
        .we    (pc_we),
        .waddr (cur_q),
        .wdata (mem_pc),
        .raddr (other),
        .rdata (switch_pc)
    );

    assign switch_tid  = other;
    assign cur_tid     = cur_q;
    assign thread_done = done_q;
    assign dbg_state   = state_q;

endmodule
